// File: rtl/txwregif_wrarb_if.sv
// ----------------------------------------------------------------------------
// txwregif_wrarb_if
// Bundles the two register-write requester ports and the FIFO write side
// of txwregif_wrarb.
//   req0/addr0/data0 -> ack0 : requester 0 (transfer when req0 & ack0)
//   req1/addr1/data1 -> ack1 : requester 1
//   wrfull -> wren/datain    : FIFO write side
//   busy, gnt_id, frame_cnt, dbg : status
// Modports: master = requesters + FIFO model side, slave = the arbiter.
// ----------------------------------------------------------------------------
interface txwregif_wrarb_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic             req0;
    logic [7:0]       addr0;
    logic [31:0]      data0;
    logic             ack0;
    logic             req1;
    logic [7:0]       addr1;
    logic [31:0]      data1;
    logic             ack1;
    logic             wrfull;
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             busy;
    logic             gnt_id;
    logic [CNTW-1:0]  frame_cnt;
    logic             dbg;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, wrfull,
        input  ack0, ack1, wren, datain, busy, gnt_id, frame_cnt, dbg
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, wrfull,
        output ack0, ack1, wren, datain, busy, gnt_id, frame_cnt, dbg
    );
endinterface

// File: rtl/txwregif_wrarb.sv
// ----------------------------------------------------------------------------
// txwregif_wrarb
// Round-robin arbiter between two register-write requesters. Each accepted
// write is serialised into a byte frame on a FIFO write port:
//   addr, data[7:0], data[15:8], data[23:16], data[31:24] (+ XOR checksum)
// Ports:
//   clk    : single clock
//   reset  : synchronous, active-high
//   bus    : txwregif_wrarb_if.slave (requesters, FIFO write side, status)
// Parameters: WIDTH (FIFO byte width, only 8 supported), CNTW (frame counter).
// Optional feature: define TXWREGIF_WRARB_CSUM_EN to append a checksum byte
// (XOR of the five preceding bytes) to every frame.
// ----------------------------------------------------------------------------
module txwregif_wrarb #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    txwregif_wrarb_if.slave  bus
);

`ifdef TXWREGIF_WRARB_CSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, D0, D1, D2, D3, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, D0, D1, D2, D3} state_t;
`endif

    state_t          state_q;
    logic            rst_dly_q;
    logic            last_gnt_q;
    logic            gnt_id_q;
    logic [CNTW-1:0] frame_cnt_q;
    logic [7:0]      addr_q;
    logic [31:0]     data_q;

    logic            blk_d;
    logic            idle_d;
    logic            grant0_d;
    logic            grant1_d;
    logic            ack0_d;
    logic            ack1_d;
    logic            busy_d;
    logic            wren_d;
    logic            last_byte_d;
    logic [7:0]      byte_d;

    always_comb begin
        // Acceptance is held off during reset and the cycle that follows it.
        blk_d    = reset | rst_dly_q;
        idle_d   = (state_q == IDLE);
        // last_gnt_q names the requester served last; the other wins a tie.
        grant0_d = bus.req0 & (~bus.req1 | last_gnt_q);
        grant1_d = bus.req1 & (~bus.req0 | ~last_gnt_q);
        ack0_d   = idle_d & ~blk_d & grant0_d;
        ack1_d   = idle_d & ~blk_d & grant1_d;
        // Outputs are forced quiet while reset is asserted, even mid-frame.
        busy_d   = ~idle_d & ~reset;
        wren_d   = busy_d & ~bus.wrfull;

        byte_d      = '0;
        last_byte_d = 1'b0;
        unique case (state_q)
            ADDR:    byte_d = addr_q;
            D0:      byte_d = data_q[7:0];
            D1:      byte_d = data_q[15:8];
            D2:      byte_d = data_q[23:16];
`ifdef TXWREGIF_WRARB_CSUM_EN
            D3:      byte_d = data_q[31:24];
            CSUM: begin
                byte_d      = addr_q ^ data_q[7:0] ^ data_q[15:8]
                            ^ data_q[23:16] ^ data_q[31:24];
                last_byte_d = 1'b1;
            end
`else
            D3: begin
                byte_d      = data_q[31:24];
                last_byte_d = 1'b1;
            end
`endif
            default: byte_d = '0;
        endcase
    end

    assign bus.ack0      = ack0_d;
    assign bus.ack1      = ack1_d;
    assign bus.busy      = busy_d;
    assign bus.wren      = wren_d;
    assign bus.dbg       = busy_d & bus.wrfull;
    assign bus.datain    = busy_d ? WIDTH'(byte_d) : '0;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.frame_cnt = frame_cnt_q;

    always_ff @(posedge clk) begin
        rst_dly_q <= reset;
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            gnt_id_q    <= 1'b0;
            frame_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ack0_d | ack1_d) begin
                        addr_q     <= ack1_d ? bus.addr1 : bus.addr0;
                        data_q     <= ack1_d ? bus.data1 : bus.data0;
                        last_gnt_q <= ack1_d;
                        gnt_id_q   <= ack1_d;
                        state_q    <= ADDR;
                    end
                end
                default: begin
                    // Each state advances only on a cycle where its byte is written.
                    if (wren_d) begin
                        if (last_byte_d) begin
                            state_q     <= IDLE;
                            frame_cnt_q <= frame_cnt_q + CNTW'(1);
                        end else begin
                            unique case (state_q)
                                ADDR:    state_q <= D0;
                                D0:      state_q <= D1;
                                D1:      state_q <= D2;
                                D2:      state_q <= D3;
`ifdef TXWREGIF_WRARB_CSUM_EN
                                D3:      state_q <= CSUM;
`endif
                                default: state_q <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txwregif_wrarb.sv
// ----------------------------------------------------------------------------
// tb_txwregif_wrarb
// Drives txwregif_wrarb (CNTW=4 so the frame counter wraps) with directed
// and random requester/FIFO-full stimulus and compares every output each
// cycle against a byte-queue model of the expected frame stream.
// ----------------------------------------------------------------------------
module tb_txwregif_wrarb;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    txwregif_wrarb_if #(.WIDTH(8), .CNTW(CW)) bus ();
    txwregif_wrarb #(.WIDTH(8), .CNTW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_last_gnt = 1'b1;
    bit         m_gnt_id   = 1'b0;
    int unsigned m_cnt     = 0;
    bit         m_rst_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step(input bit r, input bit q0, input logic [7:0] a0, input logic [31:0] d0,
                        input bit q1, input logic [7:0] a1, input logic [31:0] d1,
                        input bit wf, input bit do_chk);
        bit       blk, busy, got, win, e_ack0, e_ack1, e_wren;
        logic [7:0] e_byte;
        @(posedge clk);
        #1;
        reset = r;
        bus.req0 = q0; bus.addr0 = a0; bus.data0 = d0;
        bus.req1 = q1; bus.addr1 = a1; bus.data1 = d1;
        bus.wrfull = wf;
        #4;
        blk  = r || m_rst_prev;
        busy = !r && (m_q.size() > 0);
        got  = 1'b0;
        win  = 1'b0;
        if (m_q.size() == 0 && !blk) begin
            if (q0 && q1) begin got = 1'b1; win = ~m_last_gnt; end
            else if (q0)  begin got = 1'b1; win = 1'b0; end
            else if (q1)  begin got = 1'b1; win = 1'b1; end
        end
        e_ack0 = got && !win;
        e_ack1 = got && win;
        e_wren = busy && !wf;
        e_byte = busy ? m_q[0] : 8'h00;
        if (do_chk) begin
            check("ack0",      32'(bus.ack0),      32'(e_ack0));
            check("ack1",      32'(bus.ack1),      32'(e_ack1));
            check("busy",      32'(bus.busy),      32'(busy));
            check("wren",      32'(bus.wren),      32'(e_wren));
            check("datain",    32'(bus.datain),    32'(e_byte));
            check("dbg",       32'(bus.dbg),       32'(busy && wf));
            check("gnt_id",    32'(bus.gnt_id),    32'(m_gnt_id));
            check("frame_cnt", 32'(bus.frame_cnt), m_cnt % (1 << CW));
        end
        // Advance the model across the coming clock edge.
        if (r) begin
            m_q.delete();
            m_last_gnt = 1'b1;
            m_gnt_id   = 1'b0;
            m_cnt      = 0;
        end else if (got) begin
            logic [7:0]  a;
            logic [31:0] d;
            a = win ? a1 : a0;
            d = win ? d1 : d0;
            m_q.push_back(a);
            for (int i = 0; i < 4; i++) m_q.push_back(d[8*i +: 8]);
`ifdef TXWREGIF_WRARB_CSUM_EN
            m_q.push_back(a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
`endif
            m_last_gnt = win;
            m_gnt_id   = win;
        end else if (e_wren) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_cnt++;
        end
        m_rst_prev = r;
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 0; bus.addr1 = '0; bus.data1 = '0;
        bus.wrfull = 0;
        // Power-up reset, then a checked reset cycle.
        step(1, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0, 0, 0);
        step(1, 1, 8'h0, 32'h0, 1, 8'h0, 32'h0, 0, 1);
        // Single request 0x12 / 0xA1B2C3D4 (first cycle after reset is blocked).
        for (int i = 0; i < 10; i++)
            step(0, (i < 2), 8'h12, 32'hA1B2C3D4, 0, 8'h0, 32'h0, 0, 1);
        // Both requesters held: alternating grants, back-to-back frames.
        for (int i = 0; i < 30; i++)
            step(0, 1, 8'h20 + 8'(i), 32'h11110000 + i, 1, 8'h40 + 8'(i), 32'h22220000 + i, 0, 1);
        for (int i = 0; i < 8; i++)
            step(0, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0, 0, 1);
        // wrfull held for 3 cycles while in D1.
        for (int i = 0; i < 14; i++)
            step(0, (i == 0), 8'h5A, 32'hDEADBEEF, 0, 8'h0, 32'h0, (i >= 3 && i < 6), 1);
        // Reset during D2, then a fresh request restarts the frame.
        for (int i = 0; i < 5; i++)
            step(0, (i == 0), 8'h77, 32'h01234567, 0, 8'h0, 32'h0, 0, 1);
        step(1, 0, 8'h0, 32'h0, 0, 8'h0, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(0, 0, 8'h0, 32'h0, (i < 2), 8'h99, 32'h89ABCDEF, 0, 1);
        // Random traffic; long enough for the 4-bit frame counter to wrap.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6), 8'($urandom), $urandom,
                 ($urandom_range(0, 9) < 5), 8'($urandom), $urandom,
                 ($urandom_range(0, 4) == 0), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
